// File: rtl/mem_io_responder_pkg.sv
// Shared constants and address decode for the CPU byte-bus responder.
// The I/O window is selected by address bits [17:16] == 2'b11; inside it
// the UART port sits at 0x30000 and the cycle counter at 0x30004..0x30007.
package mem_io_responder_pkg;

    localparam int DEFAULT_RAM_ADDR_W   = 17;
    localparam int DEFAULT_TX_FIFO_LOG2 = 4;
    localparam int DEFAULT_FULL_MARGIN  = 2;
    localparam int RAM_SIZE             = 1 << DEFAULT_RAM_ADDR_W;

    localparam logic [31:0] IO_BASE      = 32'h0003_0000;
    localparam logic [31:0] IO_PORT_UART = 32'h0003_0000;
    localparam logic [31:0] IO_PORT_CLK  = 32'h0003_0004;
    localparam int          IO_SEL_HI    = 17;
    localparam int          IO_SEL_LO    = 16;

    // What a single bus cycle does, decided from address and direction.
    typedef enum logic [2:0] {
        ACC_RAM_RD,
        ACC_RAM_WR,
        ACC_UART_RD,
        ACC_UART_WR,
        ACC_CLK_RD,
        ACC_CLK_WR,
        ACC_IO_NOP
    } access_e;

    // Classify a bus cycle; only the low 18 address bits take part in decode.
    function automatic access_e decode_access(input logic [17:0] addr, input logic wr);
        access_e kind;
        if (addr[IO_SEL_HI:IO_SEL_LO] != IO_BASE[IO_SEL_HI:IO_SEL_LO]) begin
            kind = wr ? ACC_RAM_WR : ACC_RAM_RD;
        end else if (addr == IO_PORT_UART[17:0]) begin
            kind = wr ? ACC_UART_WR : ACC_UART_RD;
        end else if (addr[17:2] == IO_PORT_CLK[17:2]) begin
            // All four counter bytes are readable; only the base byte is a write port.
            if (!wr) begin
                kind = ACC_CLK_RD;
            end else begin
                kind = (addr[1:0] == 2'b00) ? ACC_CLK_WR : ACC_IO_NOP;
            end
        end else begin
            kind = ACC_IO_NOP;
        end
        return kind;
    endfunction

endpackage

// File: rtl/mem_io_responder_sync_fifo.sv
// Synchronous byte FIFO with occupancy count, used as the UART TX queue.
// Depth is 2**LOG2. Push while full is accepted only when a pop happens in
// the same cycle; pop while empty is ignored.
module sync_fifo
    import mem_io_responder_pkg::*;
#(
    parameter int LOG2 = DEFAULT_TX_FIFO_LOG2
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    pop_data,
    output logic          full,
    output logic          empty,
    output logic [LOG2:0] count
);

    localparam int DEPTH = 1 << LOG2;

    logic [7:0]      mem [DEPTH];
    logic [LOG2-1:0] wr_ptr;
    logic [LOG2-1:0] rd_ptr;
    logic [LOG2:0]   count_q;
    logic            wr_en;
    logic            rd_en;

    // Count never exceeds DEPTH, so its top bit alone means "full".
    assign full     = count_q[LOG2];
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem[rd_ptr];

    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    // Storage write port.
    // NOTE: the data array is deliberately not reset; pointers and count decide what is valid, and an unreset array can map onto RAM cells.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + LOG2'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + LOG2'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + (LOG2 + 1)'(1);
                2'b01:   count_q <= count_q - (LOG2 + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// Responder end of the CPU byte memory bus: 128KB byte RAM plus an I/O window
// holding the UART TX port and a free-running cycle counter.
// Reads return data one cycle after the address; writes complete on the edge.
// Optional feature macro IO_RX_EN: reads of 0x30000 return the received UART
// byte and pulse rx_pop; without it those reads return 0x00 and rx_pop is 0.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int RAM_ADDR_W   = DEFAULT_RAM_ADDR_W,
    parameter int TX_FIFO_LOG2 = DEFAULT_TX_FIFO_LOG2,
    parameter int FULL_MARGIN  = DEFAULT_FULL_MARGIN
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic        program_done,
    output logic        tx_overflow
);

    localparam int RAM_DEPTH = 1 << RAM_ADDR_W;
    localparam int TX_DEPTH  = 1 << TX_FIFO_LOG2;
    localparam int CW        = TX_FIFO_LOG2 + 1;

    access_e               acc_kind;
    logic [RAM_ADDR_W-1:0] ram_idx;
    logic [1:0]            clk_byte;
    logic                  unused_addr;

    assign acc_kind    = decode_access(cpu_a[17:0], cpu_wr);
    assign ram_idx     = cpu_a[RAM_ADDR_W-1:0];
    assign clk_byte    = cpu_a[1:0];
    assign unused_addr = ^cpu_a[31:18];

    // ------------------------------------------------------------------
    // Byte RAM
    // ------------------------------------------------------------------
    logic [7:0] ram [RAM_DEPTH];
    logic [7:0] ram_rd;

    // Single-port RAM: write on write cycles, registered read every cycle.
    always_ff @(posedge clk_in) begin
        if (acc_kind == ACC_RAM_WR) begin
            ram[ram_idx] <= cpu_dout;
        end
        ram_rd <= ram[ram_idx];
    end

    // ------------------------------------------------------------------
    // Cycle counter and read snapshot
    // ------------------------------------------------------------------
    logic [31:0] cycle_cnt;
    logic [31:0] snapshot;

    // Free-running counter; reading byte 0 freezes the full word so the
    // upper bytes read afterwards belong to the same sample.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cycle_cnt <= '0;
            snapshot  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if ((acc_kind == ACC_CLK_RD) && (clk_byte == 2'b00)) begin
                snapshot <= cycle_cnt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------
    logic [7:0] io_rd_next;
    logic [7:0] io_rd_q;
    logic       rd_ram_q;

    // I/O read value for this cycle's address.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        io_rd_next = 8'h00;
        case (acc_kind)
            ACC_CLK_RD: begin
                case (clk_byte)
                    2'd0:    io_rd_next = cycle_cnt[7:0];
                    2'd1:    io_rd_next = snapshot[15:8];
                    2'd2:    io_rd_next = snapshot[23:16];
                    default: io_rd_next = snapshot[31:24];
                endcase
            end
            ACC_UART_RD: begin
`ifdef IO_RX_EN
                if (rx_valid) begin
                    io_rd_next = rx_data;
                end
`endif
            end
            default: begin
                io_rd_next = 8'h00;
            end
        endcase
    end

    // Register the I/O value and remember whether the RAM word is the answer.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            io_rd_q  <= 8'h00;
            rd_ram_q <= 1'b0;
        end else begin
            io_rd_q  <= io_rd_next;
            rd_ram_q <= (acc_kind == ACC_RAM_RD);
        end
    end

    // Write cycles and I/O reads fall through to io_rd_q, which is 0 after reset.
    assign cpu_din = rd_ram_q ? ram_rd : io_rd_q;

`ifdef IO_RX_EN
    logic rx_pop_q;

    // One-cycle consume pulse for a received byte handed to the core.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rx_pop_q <= 1'b0;
        end else begin
            rx_pop_q <= (acc_kind == ACC_UART_RD) && rx_valid;
        end
    end

    assign rx_pop = rx_pop_q;
`else
    logic unused_rx;

    assign unused_rx = ^{rx_data, rx_valid};
    assign rx_pop    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    logic          push_req;
    logic [7:0]    push_data;
    logic          pop;
    logic          push_ok;
    logic          drop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_next;
    logic          near_full_next;
    logic          io_full_q;
    logic          program_done_q;
    logic          tx_overflow_q;

    // UART writes push non-zero bytes; a write to the counter port pushes a
    // 0x00 terminator.
    always_comb begin
        push_req  = 1'b0;
        push_data = cpu_dout;
        case (acc_kind)
            ACC_UART_WR: push_req = (cpu_dout != 8'h00);
            ACC_CLK_WR: begin
                push_req  = 1'b1;
                push_data = 8'h00;
            end
            default: push_req = 1'b0;
        endcase
    end

    assign pop            = tx_valid && tx_ready;
    assign push_ok        = push_req && (!fifo_full || pop);
    assign drop           = push_req && fifo_full && !pop;
    assign count_next     = fifo_count + {{(CW-1){1'b0}}, push_ok} - {{(CW-1){1'b0}}, pop};
    assign near_full_next = (TX_DEPTH - int'(count_next)) <= FULL_MARGIN;

    sync_fifo #(
        .LOG2 (TX_FIFO_LOG2)
    ) u_tx_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (push_ok),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign tx_valid = !fifo_empty;

    // Back-pressure and sticky status flags. The margin leaves room for a
    // write already in flight when the core sees io_buffer_full.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            io_full_q      <= 1'b0;
            program_done_q <= 1'b0;
            tx_overflow_q  <= 1'b0;
        end else begin
            io_full_q <= near_full_next;
            if (acc_kind == ACC_CLK_WR) begin
                program_done_q <= 1'b1;
            end
            if (drop) begin
                tx_overflow_q <= 1'b1;
            end
        end
    end

    assign io_buffer_full = io_full_q;
    assign program_done   = program_done_q;
    assign tx_overflow    = tx_overflow_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: a directed vector table, hand
// sequences for the multi-cycle cases, and a randomized phase against a
// queue/associative-array model of RAM, TX FIFO and status flags.
module tb_mem_io_responder;
    import mem_io_responder_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] cpu_a;
    logic        cpu_wr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_pop;
    logic        program_done;
    logic        tx_overflow;

    mem_io_responder dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .cpu_a          (cpu_a),
        .cpu_wr         (cpu_wr),
        .cpu_dout       (cpu_dout),
        .cpu_din        (cpu_din),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_pop         (rx_pop),
        .program_done   (program_done),
        .tx_overflow    (tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    logic [7:0] q_m[$];
    logic       ov_m = 1'b0;
    logic       pd_m = 1'b0;
    logic [7:0] ram_m [int];
    int         keys[$];
    logic [31:0] edges;

    // Bytes leaving the TX FIFO, collected while mon_en is set.
    logic       mon_en = 1'b0;
    logic [7:0] got[$];

    // Cycles elapsed since reset: the value the hardware counter should hold.
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) edges <= 32'd0;
        else         edges <= edges + 32'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_fifo(input string tag);
        check({tag, ".tx_valid"}, tx_valid, q_m.size() != 0);
        if (q_m.size() != 0) check({tag, ".tx_data"}, tx_data, q_m[0]);
        check({tag, ".io_buffer_full"}, io_buffer_full, (16 - q_m.size()) <= 2);
        check({tag, ".tx_overflow"}, tx_overflow, ov_m);
        check({tag, ".program_done"}, program_done, pd_m);
    endtask

    // One bus cycle: update the model with what the edge will do, then wait
    // until the opposite edge where outputs are sampled.
    task automatic op(input logic [31:0] a, input logic wr, input logic [7:0] d);
        logic is_io;
        bit   push;
        bit   popping;
        logic [7:0] pd;
        is_io   = (a[17:16] == 2'b11);
        push    = 1'b0;
        pd      = d;
        popping = (q_m.size() != 0) && tx_ready;
        if (wr && is_io && a[15:0] == 16'h0000 && d != 8'h00) push = 1'b1;
        if (wr && is_io && a[15:0] == 16'h0004) begin
            push = 1'b1;
            pd   = 8'h00;
            pd_m = 1'b1;
        end
        if (wr && !is_io) begin
            ram_m[int'(a[16:0])] = d;
            keys.push_back(int'(a[16:0]));
        end
        if (mon_en && tx_valid && tx_ready) got.push_back(tx_data);
        if (popping) void'(q_m.pop_front());
        if (push) begin
            if (q_m.size() < 16) q_m.push_back(pd);
            else ov_m = 1'b1;
        end
        cpu_a    = a;
        cpu_wr   = wr;
        cpu_dout = d;
        @(negedge clk_in);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
    task automatic do_reset(input string tag);
        #2 rst_in = 1'b0;
        #1;
        q_m.delete();
        ov_m = 1'b0;
        pd_m = 1'b0;
        check({tag, ".cpu_din"}, cpu_din, 8'h00);
        check({tag, ".io_buffer_full"}, io_buffer_full, 1'b0);
        check({tag, ".tx_valid"}, tx_valid, 1'b0);
        check({tag, ".program_done"}, program_done, 1'b0);
        check({tag, ".tx_overflow"}, tx_overflow, 1'b0);
        check({tag, ".rx_pop"}, rx_pop, 1'b0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    typedef struct {
        logic [31:0] a;
        logic        wr;
        logic [7:0]  d;
        logic        chk;
        logic [7:0]  exp;
    } vec_t;

    vec_t tbl[17];

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected the test to complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] snap;
        logic [7:0]  exp_rx;
        logic        exp_pop;

        rst_in   = 1'b1;
        cpu_a    = 32'h0;
        cpu_wr   = 1'b0;
        cpu_dout = 8'h00;
        tx_ready = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        @(negedge clk_in);
        do_reset("reset0");

        // Directed vectors: RAM round trips, boundaries, aliasing, idle I/O.
        tbl = '{
            '{32'h0000_0010, 1'b1, 8'hA5, 1'b0, 8'h00},
            '{32'h0000_0010, 1'b0, 8'h00, 1'b1, 8'hA5},
            '{32'h0000_0000, 1'b1, 8'h11, 1'b0, 8'h00},
            '{32'(RAM_SIZE - 1), 1'b1, 8'h22, 1'b0, 8'h00},
            '{32'(RAM_SIZE - 1), 1'b0, 8'h00, 1'b1, 8'h22},
            '{32'h0000_0000, 1'b0, 8'h00, 1'b1, 8'h11},
            '{32'h0001_0000, 1'b1, 8'h33, 1'b0, 8'h00},
            '{32'h0001_0000, 1'b0, 8'h00, 1'b1, 8'h33},
            '{32'h0002_0010, 1'b0, 8'h00, 1'b1, 8'hA5},
            '{32'h0003_0010, 1'b1, 8'h77, 1'b0, 8'h00},
            '{32'h0003_0010, 1'b0, 8'h00, 1'b1, 8'h00},
            '{32'h0003_FFFF, 1'b0, 8'h00, 1'b1, 8'h00},
            '{32'h0002_0000, 1'b1, 8'h44, 1'b0, 8'h00},
            '{32'h0000_0000, 1'b0, 8'h00, 1'b1, 8'h44},
            '{32'h0003_0001, 1'b1, 8'h55, 1'b0, 8'h00},
            '{IO_PORT_UART,  1'b0, 8'h00, 1'b1, 8'h00},
            '{32'hFFF0_0010, 1'b0, 8'h00, 1'b1, 8'hA5}
        };
        foreach (tbl[i]) begin
            op(tbl[i].a, tbl[i].wr, tbl[i].d);
            if (tbl[i].chk) check($sformatf("vec%0d.cpu_din", i), cpu_din, tbl[i].exp);
        end
        check_fifo("vec_end");
        check("vec_end.rx_pop", rx_pop, 1'b0);

        // "Hi" then a zero byte: only the two letters reach the UART.
        tx_ready = 1'b1;
        got.delete();
        mon_en = 1'b1;
        op(IO_PORT_UART, 1'b1, 8'h48);
        check_fifo("hi_h");
        op(IO_PORT_UART, 1'b1, 8'h69);
        op(IO_PORT_UART, 1'b1, 8'h00);
        repeat (4) op(32'h100, 1'b0, 8'h00);
        mon_en = 1'b0;
        check("hi.count", got.size(), 2);
        if (got.size() == 2) begin
            check("hi.byte0", got[0], 8'h48);
            check("hi.byte1", got[1], 8'h69);
        end
        check_fifo("hi_end");

        // Randomized traffic: slow drain first so the FIFO fills, then fast.
        for (int i = 0; i < 400; i++) begin
            int          r;
            int          idx;
            logic [31:0] a;
            logic [7:0]  d;
            logic [7:0]  e;
            tx_ready = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            r = int'($urandom_range(0, 9));
            if (r < 3) begin
                d = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                op(IO_PORT_UART, 1'b1, d);
                check_fifo("rnd_uart");
            end else if (r < 6 || keys.size() == 0) begin
                a = ($urandom_range(0, 1) != 0) ? 32'h0001_FFC0 : 32'h0;
                a = a | 32'($urandom_range(0, 63));
                d = 8'($urandom());
                op(a, 1'b1, d);
                check_fifo("rnd_wr");
            end else begin
                idx = keys[$urandom_range(0, keys.size() - 1)];
                e   = ram_m[idx];
                op(32'(idx), 1'b0, 8'h00);
                check("rnd_rd.cpu_din", cpu_din, e);
                check_fifo("rnd_rd");
            end
        end
        tx_ready = 1'b1;
        repeat (20) op(32'h0, 1'b0, 8'h00);
        check_fifo("rnd_drained");

        // Fill with the UART stalled: near-full after 14, overflow on 17.
        do_reset("reset1");
        tx_ready = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            op(IO_PORT_UART, 1'b1, 8'(i));
            check_fifo($sformatf("fill%0d", i));
        end
        tx_ready = 1'b1;
        got.delete();
        mon_en = 1'b1;
        repeat (18) op(32'h0, 1'b0, 8'h00);
        mon_en = 1'b0;
        check("fill.drained", got.size(), 16);
        for (int k = 0; k < got.size(); k++) check($sformatf("fill.byte%0d", k), got[k], 8'(k + 1));
        check_fifo("fill_end");

        // Counter read: all four bytes come from the sample taken at 0x30004.
        repeat (300) op(32'h0, 1'b0, 8'h00);
        snap = edges;
        op(IO_PORT_CLK, 1'b0, 8'h00);
        check("clk.byte0", cpu_din, snap[7:0]);
        op(IO_PORT_CLK + 32'd1, 1'b0, 8'h00);
        check("clk.byte1", cpu_din, snap[15:8]);
        op(IO_PORT_CLK + 32'd2, 1'b0, 8'h00);
        check("clk.byte2", cpu_din, snap[23:16]);
        op(IO_PORT_CLK + 32'd3, 1'b0, 8'h00);
        check("clk.byte3", cpu_din, snap[31:24]);
        repeat (5) op(32'h0, 1'b0, 8'h00);
        op(IO_PORT_CLK + 32'd1, 1'b0, 8'h00);
        check("clk.byte1_again", cpu_din, snap[15:8]);

        // Program stop: terminator byte queued, flag set, then reset mid-transfer.
        tx_ready = 1'b0;
        op(IO_PORT_CLK, 1'b1, 8'h99);
        check_fifo("done");
        op(IO_PORT_UART, 1'b1, 8'h5A);
        check_fifo("done_more");
        tx_ready = 1'b1;
        do_reset("reset2");
        snap = edges;
        op(IO_PORT_CLK, 1'b0, 8'h00);
        check("post_reset.clk", cpu_din, snap[7:0]);
        check_fifo("post_reset");

        // UART receive port.
`ifdef IO_RX_EN
        exp_rx  = 8'h37;
        exp_pop = 1'b1;
`else
        exp_rx  = 8'h00;
        exp_pop = 1'b0;
`endif
        rx_data  = 8'h37;
        rx_valid = 1'b1;
        op(IO_PORT_UART, 1'b0, 8'h00);
        check("rx.cpu_din", cpu_din, exp_rx);
        check("rx.rx_pop", rx_pop, exp_pop);
        rx_valid = 1'b0;
        op(32'h100, 1'b0, 8'h00);
        check("rx.pop_single", rx_pop, 1'b0);
        op(IO_PORT_UART, 1'b0, 8'h00);
        check("rx_empty.cpu_din", cpu_din, 8'h00);
        check("rx_empty.rx_pop", rx_pop, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
